// File: rtl/tm_key_events.sv
// Key-event front end for the TM1638 scan byte. It debounces the 8 raw key bits,
// turns each debounced transition into a press/release event, and queues the
// events in a first-word-fall-through FIFO that is read through valid/ready.
module tm_key_events #(
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  keys_raw,
    input  logic                        keys_valid,
    output logic [7:0]                  keys_stable,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [3:0]                  ev_data,
    output logic [$clog2(FIFO_DEPTH):0] ev_count,
    output logic                        ev_overflow,
    input  logic                        clr_overflow
);

    localparam int unsigned    AddrW  = $clog2(FIFO_DEPTH);
    localparam logic [3:0]     CntMax = 4'(DEBOUNCE_SCANS - 1);
    localparam logic [AddrW:0] DepthC = (AddrW + 1)'(FIFO_DEPTH);

    logic [3:0]       cnt_q [8];
    logic [3:0]       cnt_d [8];
    logic [7:0]       stable_q, stable_d;
    logic [7:0]       raise;
    logic [7:0]       pend_q, pend_d;
    logic [7:0]       ptype_q, ptype_d;
    logic             ovf_q, ovf_d;
    logic             collide;

    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [AddrW:0]   count_q;
    logic             full, pop, push, any_pend;
    logic [2:0]       sel;
    logic [7:0]       clr_mask;

    // Debounce: count consecutive differing scans per key, flip and raise an event at the limit.
    always_comb begin
        stable_d = stable_q;
        raise    = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (keys_valid) begin
                if (keys_raw[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    stable_d[i] = keys_raw[i];
                    cnt_d[i]    = '0;
                    raise[i]    = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Arbiter: lowest pending key index wins the single push slot.
    always_comb begin
        sel      = '0;
        any_pend = |pend_q;
        for (int i = 7; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel = 3'(i);
            end
        end
        full     = (count_q == DepthC);
        pop      = ev_valid && ev_ready;
        push     = any_pend && (!full || pop);
        clr_mask = push ? (8'b1 << sel) : 8'b0;
    end

    // Pending stage: the push clear lands first, so a raise on a just-pushed key is a fresh set,
    // while a raise on a still-pending key cancels both events and flags the loss.
    always_comb begin
        pend_d  = pend_q & ~clr_mask;
        ptype_d = ptype_q;
        collide = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (raise[i]) begin
                if (pend_d[i]) begin
                    pend_d[i] = 1'b0;
                    collide   = 1'b1;
                end else begin
                    pend_d[i]  = 1'b1;
                    ptype_d[i] = stable_d[i];
                end
            end
        end
        if (collide) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Debounce, pending and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '0;
            pend_q   <= '0;
            ptype_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_d;
            pend_q   <= pend_d;
            ptype_q  <= ptype_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // FIFO storage; contents beyond the occupancy are never observed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {ptype_q[sel], sel};
        end
    end

    // Outputs: head falls through while non-empty, zero otherwise.
    always_comb begin
        keys_stable = stable_q;
        ev_valid    = (count_q != '0);
        ev_count    = count_q;
        ev_data     = ev_valid ? mem_q[rptr_q] : 4'h0;
        ev_overflow = ovf_q;
    end

endmodule

// File: tb/tb_tm_key_events.sv
// Bench for tm_key_events: directed scenarios followed by random traffic, all checked
// every cycle against an event-level reference model.
module tb_tm_key_events;

    localparam int unsigned DEB   = 4;
    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] keys_raw;
    logic       keys_valid;
    logic [7:0] keys_stable;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] ev_data;
    logic [3:0] ev_count;
    logic       ev_overflow;
    logic       clr_overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit   [7:0] m_stable;
    int         m_run [8];
    bit   [7:0] m_pend;
    bit   [7:0] m_ptype;
    logic [3:0] m_q [$];
    bit         m_ov;

    tm_key_events #(
        .DEBOUNCE_SCANS(DEB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .keys_raw    (keys_raw),
        .keys_valid  (keys_valid),
        .keys_stable (keys_stable),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_data     (ev_data),
        .ev_count    (ev_count),
        .ev_overflow (ev_overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_tick();
        int j;
        bit collide;
        if (rst) begin
            m_stable = '0;
            m_pend   = '0;
            m_ptype  = '0;
            m_ov     = 1'b0;
            m_q.delete();
            for (int k = 0; k < 8; k++) m_run[k] = 0;
            return;
        end
        j = -1;
        for (int k = 0; k < 8; k++) if (m_pend[k] && j < 0) j = k;
        if (m_q.size() > 0 && ev_ready) void'(m_q.pop_front());
        if (j >= 0 && m_q.size() < DEPTH) begin
            m_q.push_back({m_ptype[j], 3'(j)});
            m_pend[j] = 1'b0;
        end
        collide = 1'b0;
        if (keys_valid) begin
            for (int k = 0; k < 8; k++) begin
                if (keys_raw[k] == m_stable[k]) begin
                    m_run[k] = 0;
                end else begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_stable[k] = keys_raw[k];
                        m_run[k]    = 0;
                        if (m_pend[k]) begin
                            m_pend[k] = 1'b0;
                            collide   = 1'b1;
                        end else begin
                            m_pend[k]  = 1'b1;
                            m_ptype[k] = keys_raw[k];
                        end
                    end
                end
            end
        end
        if (collide) m_ov = 1'b1;
        else if (clr_overflow) m_ov = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("keys_stable", keys_stable, m_stable);
        check("ev_valid", {7'b0, ev_valid}, {7'b0, m_q.size() > 0});
        check("ev_count", {4'b0, ev_count}, 8'(m_q.size()));
        check("ev_data", {4'b0, ev_data}, (m_q.size() > 0) ? {4'b0, m_q[0]} : 8'h00);
        check("ev_overflow", {7'b0, ev_overflow}, {7'b0, m_ov});
    endtask

    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic strobe(input logic [7:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            keys_raw   = v;
            keys_valid = 1'b1;
            cycle();
        end
        keys_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        keys_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        keys_raw     = 8'h00;
        keys_valid   = 1'b0;
        ev_ready     = 1'b0;
        clr_overflow = 1'b0;

        // Reset state.
        do_reset();
        check("rst_valid", {7'b0, ev_valid}, 8'h00);
        check("rst_count", {4'b0, ev_count}, 8'h00);
        check("rst_data", {4'b0, ev_data}, 8'h00);
        check("rst_stable", keys_stable, 8'h00);

        // Single press of key 2 and its latency.
        strobe(8'h04, 3);
        check("t1_stable_early", keys_stable, 8'h00);
        strobe(8'h04, 1);
        check("t1_stable", keys_stable, 8'h04);
        check("t1_valid_n1", {7'b0, ev_valid}, 8'h00);
        idle(1);
        check("t1_valid_n2", {7'b0, ev_valid}, 8'h01);
        check("t1_data", {4'b0, ev_data}, 8'h0A);

        // Interrupted run restarts the debounce count.
        do_reset();
        strobe(8'h04, 3);
        strobe(8'h00, 1);
        strobe(8'h04, 3);
        idle(2);
        check("t2_no_event", {4'b0, ev_count}, 8'h00);
        strobe(8'h04, 1);
        idle(1);
        check("t2_count", {4'b0, ev_count}, 8'h01);
        check("t2_data", {4'b0, ev_data}, 8'h0A);
        idle(3);
        check("t2_single", {4'b0, ev_count}, 8'h01);

        // Two simultaneous presses queue lowest index first.
        do_reset();
        strobe(8'h81, 4);
        idle(2);
        check("t3_count", {4'b0, ev_count}, 8'h02);
        check("t3_head0", {4'b0, ev_data}, 8'h08);
        ev_ready = 1'b1;
        cycle();
        ev_ready = 1'b0;
        check("t3_head1", {4'b0, ev_data}, 8'h0F);

        // Full FIFO: ninth event waits in pend, enters on the first pop.
        do_reset();
        strobe(8'hFF, 4);
        idle(8);
        check("t4_full", {4'b0, ev_count}, 8'h08);
        strobe(8'hFE, 4);
        idle(2);
        check("t4_still_full", {4'b0, ev_count}, 8'h08);
        ev_ready = 1'b1;
        cycle();
        ev_ready = 1'b0;
        check("t4_refill", {4'b0, ev_count}, 8'h08);
        check("t4_head", {4'b0, ev_data}, 8'h09);
        idle(1);
        check("t4_no_ovf", {7'b0, ev_overflow}, 8'h00);

        // Press then release of key 0 while full collide and are lost.
        strobe(8'hFF, 4);
        strobe(8'hFE, 4);
        check("t5_ovf", {7'b0, ev_overflow}, 8'h01);
        check("t5_stable", keys_stable, 8'hFE);
        clr_overflow = 1'b1;
        cycle();
        clr_overflow = 1'b0;
        check("t5_ovf_clr", {7'b0, ev_overflow}, 8'h00);
        ev_ready = 1'b1;
        idle(9);
        ev_ready = 1'b0;
        check("t5_drained", {4'b0, ev_count}, 8'h00);

        // Reset with queued and pending events.
        do_reset();
        strobe(8'h07, 4);
        idle(3);
        check("t6_count", {4'b0, ev_count}, 8'h03);
        strobe(8'h0F, 4);
        check("t6_pending", {4'b0, ev_count}, 8'h03);
        do_reset();
        check("t6_valid", {7'b0, ev_valid}, 8'h00);
        check("t6_count0", {4'b0, ev_count}, 8'h00);
        check("t6_stable", keys_stable, 8'h00);
        check("t6_ovf", {7'b0, ev_overflow}, 8'h00);
        strobe(8'h0F, 3);
        check("t6_held_early", keys_stable, 8'h00);
        strobe(8'h0F, 1);
        check("t6_held", keys_stable, 8'h0F);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(9) == 0) keys_raw = keys_raw ^ (8'($urandom) & 8'($urandom));
            keys_valid   = ($urandom_range(1) == 1);
            ev_ready     = ($urandom_range(2) == 0);
            clr_overflow = ($urandom_range(15) == 0);
            rst          = ($urandom_range(499) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
